// File: rtl/mux_scan_pkg.sv
// Shared constants and helpers for the N-channel scan multiplexer.
// Channel slices are packed most-significant first: channel 0 occupies the top W bits.
package mux_scan_pkg;

  localparam int DEF_DIV       = 100000;
  localparam int DEF_BLANK_CYC = 16;

  // Channel 0 is the most-significant slice of the packed data bus.
  localparam bit SLICE_MSB_FIRST = 1'b1;

  // Ceiling log2, never below 1 so it can size a register directly.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // LSB position of channel k inside a CH*W packed bus.
  function automatic int slice_lsb(input int ch, input int k, input int w);
    return SLICE_MSB_FIRST ? (ch - 1 - k) * w : k * w;
  endfunction

endpackage

// File: rtl/mux_scan_nchan_if.sv
// Data/control bundle between the display registers and the scan multiplexer.
// master drives the inputs and observes the outputs; slave is the multiplexer side.
interface mux_scan_nchan_if #(
  parameter int CH = 4,
  parameter int W  = 4
);
  localparam int IW = $clog2(CH);

  logic            en;
  logic            auto;
  logic [IW-1:0]   sel;
  logic [CH*W-1:0] data_in;
  logic [W-1:0]    data_out;
  logic [CH-1:0]   an_n;
  logic [IW-1:0]   ch_idx;
  logic            scan_wrap;

  modport master (
    output en, auto, sel, data_in,
    input  data_out, an_n, ch_idx, scan_wrap
  );

  modport slave (
    input  en, auto, sel, data_in,
    output data_out, an_n, ch_idx, scan_wrap
  );
endinterface

// File: rtl/mux_scan_nchan_scan_prescaler.sv
// Scan-rate prescaler: counts 0..DIV-1 while enabled and pulses tick on the last count.
// reset also serves as a hold-at-zero clear from the parent.
module scan_prescaler
  import mux_scan_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int            CW   = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = en && (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end
endmodule

// File: rtl/mux_scan_nchan.sv
// N-channel W-bit time-division multiplexer with auto scan or manual select, registered outputs.
// Define MUX_SCAN_BLANK_EN to blank an_n for BLANK_CYC enabled cycles after each channel change.
module mux_scan_nchan
  import mux_scan_pkg::*;
#(
  parameter int CH        = 4,
  parameter int W         = 4,
  parameter int DIV       = DEF_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic            clk,
  input  logic            reset,
  mux_scan_nchan_if.slave bus
);
  localparam int IW = $clog2(CH);

  if (CH < 2 || CH > 16 || DIV < 1 || BLANK_CYC < 1) begin : g_bad_param
    $error("mux_scan_nchan: parameter out of range");
  end

  logic [IW-1:0] ch_idx_reg, ch_idx_next;
  logic [W-1:0]  data_out_reg;
  logic [CH-1:0] an_n_reg, an_n_next;
  logic          scan_wrap_reg, wrap_next;
  logic          tick, pre_en, pre_clr, blank_hold;
  logic [W-1:0]  slices [CH];

  for (genvar gi = 0; gi < CH; gi++) begin : g_slice
    assign slices[gi] = bus.data_in[slice_lsb(CH, gi, W) +: W];
  end

  // Manual mode keeps the prescaler parked at zero so auto resumes with a full dwell.
  assign pre_en  = bus.en & bus.auto;
  assign pre_clr = reset | (bus.en & ~bus.auto);

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (pre_clr),
    .en    (pre_en),
    .tick  (tick)
  );

  always_comb begin
    ch_idx_next = ch_idx_reg;
    if (bus.auto) begin
      if (tick) begin
        ch_idx_next = (ch_idx_reg == IW'(CH - 1)) ? '0 : ch_idx_reg + IW'(1);
      end
    end else if ({1'b0, bus.sel} < (IW + 1)'(CH)) begin
      ch_idx_next = bus.sel;
    end
  end

  assign wrap_next = tick && (ch_idx_reg == IW'(CH - 1));
  assign an_n_next = ~(CH'(1) << ch_idx_reg);

`ifdef MUX_SCAN_BLANK_EN
  localparam int BW = clog2(BLANK_CYC + 1);

  if (BLANK_CYC >= DIV) begin : g_bad_blank
    $error("mux_scan_nchan: BLANK_CYC must be below DIV");
  end

  logic [BW-1:0] blank_cnt_reg;
  logic          ch_change;

  assign ch_change  = (ch_idx_next != ch_idx_reg);
  // The change edge itself blanks, so BLANK_CYC-1 further edges stay dark.
  assign blank_hold = ch_change || (blank_cnt_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_cnt_reg <= '0;
    end else if (bus.en) begin
      if (ch_change) begin
        blank_cnt_reg <= BW'(BLANK_CYC - 1);
      end else if (blank_cnt_reg != '0) begin
        blank_cnt_reg <= blank_cnt_reg - BW'(1);
      end
    end
  end
`else
  assign blank_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_idx_reg    <= '0;
      data_out_reg  <= '0;
      an_n_reg      <= '1;
      scan_wrap_reg <= 1'b0;
    end else if (!bus.en) begin
      scan_wrap_reg <= 1'b0;
    end else begin
      ch_idx_reg    <= ch_idx_next;
      scan_wrap_reg <= wrap_next;
      if (blank_hold) begin
        an_n_reg <= '1;
      end else begin
        data_out_reg <= slices[ch_idx_reg];
        an_n_reg     <= an_n_next;
      end
    end
  end

  assign bus.ch_idx    = ch_idx_reg;
  assign bus.data_out  = data_out_reg;
  assign bus.an_n      = an_n_reg;
  assign bus.scan_wrap = scan_wrap_reg;
endmodule

// File: tb/tb_mux_scan_nchan.sv
// Self-checking bench for mux_scan_nchan: CH=4, W=4, DIV=3, data 16'hA5C3, plus a CH=3 instance.
// Vectors hold hand-derived expectations; a queue scoreboard pairs each drive with its check.
module tb_mux_scan_nchan;
  localparam int CH = 4;
  localparam int W  = 4;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       auto;
    logic [1:0] sel;
    logic [3:0] data;
    logic [3:0] an;
    logic [1:0] idx;
    logic       wrap;
  } vec_t;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] an;
    logic [1:0] idx;
    logic       wrap;
  } exp_t;

  localparam logic [3:0] DIG [4] = '{4'hA, 4'h5, 4'hC, 4'h3};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb [$];
  vec_t vt [$];

  always #5 clk = ~clk;

  mux_scan_nchan_if #(.CH(4), .W(4)) bus ();
  mux_scan_nchan_if #(.CH(3), .W(4)) bus3 ();

  mux_scan_nchan #(.CH(4), .W(4), .DIV(3), .BLANK_CYC(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mux_scan_nchan #(.CH(3), .W(4), .DIV(3), .BLANK_CYC(1)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  function automatic vec_t v(input bit r, input bit e, input bit a, input int s,
                             input int d, input int an, input int idx, input bit w);
    vec_t t;
    t.rst = r; t.en = e; t.auto = a; t.sel = 2'(s);
    t.data = 4'(d); t.an = 4'(an); t.idx = 2'(idx); t.wrap = w;
    return t;
  endfunction

  task automatic check_out(input string tag, input int id);
    exp_t e;
    e = sb.pop_front();
    n_vec++;
    if (bus.data_out !== e.data || bus.an_n !== e.an || bus.ch_idx !== e.idx ||
        bus.scan_wrap !== e.wrap) begin
      n_err++;
      $display("FAIL %s #%0d: got data=%h an=%b idx=%0d wrap=%b, want data=%h an=%b idx=%0d wrap=%b",
               tag, id, bus.data_out, bus.an_n, bus.ch_idx, bus.scan_wrap,
               e.data, e.an, e.idx, e.wrap);
    end else begin
      $display("%s #%0d ok: data=%h an=%b idx=%0d wrap=%b",
               tag, id, bus.data_out, bus.an_n, bus.ch_idx, bus.scan_wrap);
    end
  endtask

  task automatic push_step(input string tag, input int id, input logic [3:0] d,
                           input logic [3:0] an, input logic [1:0] idx, input logic w);
    exp_t e;
    e.data = d; e.an = an; e.idx = idx; e.wrap = w;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag, id);
  endtask

  task automatic apply(input vec_t t, input int id);
    reset    = t.rst;
    bus.en   = t.en;
    bus.auto = t.auto;
    bus.sel  = t.sel;
    push_step("tbl", id, t.data, t.an, t.idx, t.wrap);
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end else begin
      $display("%s ok: %0h", name, got);
    end
  endtask

  initial begin
    int wraps;
    int idx, pidx;
    logic [3:0] an_e;

    bus.en = 1'b1; bus.auto = 1'b1; bus.sel = '0; bus.data_in = 16'hA5C3;
    bus3.en = 1'b0; bus3.auto = 1'b0; bus3.sel = '0; bus3.data_in = 12'hA5C;

`ifndef MUX_SCAN_BLANK_EN
    vt.push_back(v(1,1,1,0, 'h0,'hF,0,0));
    vt.push_back(v(1,1,1,0, 'h0,'hF,0,0));
    vt.push_back(v(0,1,1,0, 'hA,'hE,0,0));
    vt.push_back(v(0,1,1,0, 'hA,'hE,0,0));
    vt.push_back(v(0,1,1,0, 'hA,'hE,1,0));
    vt.push_back(v(0,1,1,0, 'h5,'hD,1,0));
    vt.push_back(v(0,1,1,0, 'h5,'hD,1,0));
    vt.push_back(v(0,1,1,0, 'h5,'hD,2,0));
    vt.push_back(v(0,1,1,0, 'hC,'hB,2,0));
    vt.push_back(v(0,1,1,0, 'hC,'hB,2,0));
    vt.push_back(v(0,1,1,0, 'hC,'hB,3,0));
    vt.push_back(v(0,1,1,0, 'h3,'h7,3,0));
    vt.push_back(v(0,1,1,0, 'h3,'h7,3,0));
    vt.push_back(v(0,1,1,0, 'h3,'h7,0,1));
    vt.push_back(v(0,1,1,0, 'hA,'hE,0,0));
    vt.push_back(v(0,1,1,0, 'hA,'hE,0,0));
    vt.push_back(v(0,1,1,0, 'hA,'hE,1,0));
    vt.push_back(v(0,1,1,0, 'h5,'hD,1,0));
    for (int i = 0; i < 5; i++) vt.push_back(v(0,0,1,0, 'h5,'hD,1,0));
    vt.push_back(v(0,1,1,0, 'h5,'hD,1,0));
    vt.push_back(v(0,1,1,0, 'h5,'hD,2,0));
    vt.push_back(v(0,1,1,0, 'hC,'hB,2,0));
    vt.push_back(v(0,1,0,3, 'hC,'hB,3,0));
    vt.push_back(v(0,1,0,2, 'h3,'h7,2,0));
    vt.push_back(v(0,1,0,2, 'hC,'hB,2,0));
    vt.push_back(v(0,1,0,1, 'hC,'hB,1,0));
    vt.push_back(v(0,1,0,1, 'h5,'hD,1,0));
    vt.push_back(v(0,1,1,1, 'h5,'hD,1,0));
    vt.push_back(v(0,1,1,1, 'h5,'hD,1,0));
    vt.push_back(v(0,1,1,1, 'h5,'hD,2,0));
    vt.push_back(v(0,1,0,0, 'hC,'hB,0,0));
    vt.push_back(v(0,1,0,0, 'hA,'hE,0,0));
    vt.push_back(v(0,0,0,3, 'hA,'hE,0,0));
    vt.push_back(v(0,1,0,3, 'hA,'hE,3,0));
    vt.push_back(v(0,1,1,3, 'h3,'h7,3,0));
    vt.push_back(v(1,1,1,3, 'h0,'hF,0,0));
    vt.push_back(v(0,1,1,3, 'hA,'hE,0,0));
    vt.push_back(v(1,0,1,3, 'h0,'hF,0,0));
    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Three full scan periods from reset: one wrap pulse every 12 cycles.
    reset = 1'b0; bus.en = 1'b1; bus.auto = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 36; k++) begin
      idx  = (k / 3) % 4;
      pidx = ((k - 1) / 3) % 4;
      an_e = ~(4'b0001 << pidx);
      push_step("scan", k, DIG[pidx], an_e, 2'(idx), (k % 12) == 0);
      if (bus.scan_wrap === 1'b1) wraps++;
    end
    cmp("wrap_count", 32'(wraps), 32'd3);
`else
    apply(v(1,1,1,0, 'h0,'hF,0,0), 0);
    apply(v(1,1,1,0, 'h0,'hF,0,0), 1);
    reset = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      idx  = (k / 3) % 4;
      pidx = ((k - 1) / 3) % 4;
      if (k % 3 == 0) begin
        push_step("blank", k, DIG[pidx], 4'hF, 2'(idx), (k % 12) == 0);
      end else begin
        an_e = ~(4'b0001 << idx);
        push_step("blank", k, DIG[idx], an_e, 2'(idx), 1'b0);
      end
    end
    bus.auto = 1'b0; bus.sel = 2'd2;
    push_step("blank_man", 0, 4'h3, 4'hF, 2'd2, 1'b0);
    push_step("blank_man", 1, 4'hC, 4'hB, 2'd2, 1'b0);
`endif

    // CH=3: an out-of-range select leaves the index where it was.
    reset = 1'b0;
    bus3.en = 1'b1; bus3.auto = 1'b0; bus3.sel = 2'd2;
    @(posedge clk); #1;
    cmp("ch3_sel2_idx", 32'(bus3.ch_idx), 32'd2);
    bus3.sel = 2'd3;
    @(posedge clk); #1;
    cmp("ch3_sel3_idx", 32'(bus3.ch_idx), 32'd2);
    @(posedge clk); #1;
    cmp("ch3_sel3_idx_hold", 32'(bus3.ch_idx), 32'd2);
    cmp("ch3_data", 32'(bus3.data_out), 32'hC);
    bus3.sel = 2'd0;
    @(posedge clk); #1;
    cmp("ch3_sel0_idx", 32'(bus3.ch_idx), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
